pitch_detector: RTL

- Measures the fundamental period of the sampled waveform produced by the oscillator, i.e. the receive end of the key-to-voltage path.
- Tracks peaks with hysteresis and reports the peak-to-peak period in samples, plus a lock indication.
- Sits on the voltage sample stream and is used for in-system tuning checks and by benches for self-checking frequency.

---
 rtl/pitch_detector.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/pitch_detector.sv
// Peak-to-peak period meter with hysteresis, lock flag and silence timeout.
// Optional: define PITCH_DETECTOR_AVG_EN to report the mean of the last 4 raw periods.
module pitch_detector #(
  parameter int unsigned VOLT_W  = 16,
  parameter int unsigned CNT_W   = 24,
  parameter int unsigned HYST    = 8,
  parameter int unsigned TOL     = 2,
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [VOLT_W-1:0] v,
  input  logic              v_valid,
  output logic [CNT_W-1:0]  period,
  output logic              period_valid,
  output logic              locked,
  output logic              timeout
);

  localparam int unsigned VExtW = VOLT_W + 1;

  typedef enum logic [1:0] {StInit, StRise, StFall} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  max_idx_q, max_idx_d;
  logic [CNT_W-1:0]  last_idx_q, last_idx_d;
  logic [CNT_W-1:0]  prev_p_q, prev_p_d;
  logic [CNT_W-1:0]  period_q, period_d;
  logic [CNT_W-1:0]  sil_q, sil_d;
  logic [VOLT_W-1:0] max_q, max_d;
  logic [VOLT_W-1:0] min_q, min_d;
  logic              have_peak_q, have_peak_d;
  logic              have_prev_q, have_prev_d;
  logic              locked_q, locked_d;
  logic              pv_q, pv_d;
  logic              to_q, to_d;

  logic [VExtW-1:0]  v_ext, v_plus_h, max_ext, min_plus_h;
  logic [CNT_W-1:0]  raw_p, p_diff, sil_inc;
  logic              peak, raw_upd, sil_hit, timeout_evt;

  // Hysteresis sums are one bit wider so v + HYST cannot wrap.
  assign v_ext       = {1'b0, v};
  assign v_plus_h    = v_ext + VExtW'(HYST);
  assign max_ext     = {1'b0, max_q};
  assign min_plus_h  = {1'b0, min_q} + VExtW'(HYST);
  assign raw_p       = max_idx_q - last_idx_q;
  assign p_diff      = (raw_p >= prev_p_q) ? raw_p - prev_p_q : prev_p_q - raw_p;
  assign sil_inc     = sil_q + CNT_W'(1);
  assign sil_hit     = (sil_inc == CNT_W'(TIMEOUT));
  assign timeout_evt = v_valid && !peak && sil_hit;

  // Extreme tracker; a peak event fires when a RISE run falls HYST below its maximum.
  always_comb begin
    state_d   = state_q;
    max_d     = max_q;
    min_d     = min_q;
    max_idx_d = max_idx_q;
    peak      = 1'b0;
    if (v_valid) begin
      unique case (state_q)
        StInit: begin
          max_d     = v;
          min_d     = v;
          max_idx_d = idx_q;
          state_d   = StRise;
        end
        StRise: begin
          if (v > max_q) begin
            max_d     = v;
            max_idx_d = idx_q;
          end else if (v_plus_h < max_ext) begin
            peak    = 1'b1;
            min_d   = v;
            state_d = StFall;
          end
        end
        StFall: begin
          if (v < min_q) begin
            min_d = v;
          end else if (v_ext > min_plus_h) begin
            max_d     = v;
            max_idx_d = idx_q;
            state_d   = StRise;
          end
        end
        default: state_d = StInit;
      endcase
      if (!peak && sil_hit) begin
        state_d = StInit;
      end
    end
  end

  // Sample index, silence counter, raw period bookkeeping and lock.
  always_comb begin
    idx_d       = idx_q;
    sil_d       = sil_q;
    last_idx_d  = last_idx_q;
    have_peak_d = have_peak_q;
    have_prev_d = have_prev_q;
    prev_p_d    = prev_p_q;
    locked_d    = locked_q;
    to_d        = 1'b0;
    raw_upd     = 1'b0;
    if (v_valid) begin
      idx_d = idx_q + CNT_W'(1);
      sil_d = sil_inc;
      if (peak) begin
        sil_d       = '0;
        last_idx_d  = max_idx_q;
        have_peak_d = 1'b1;
        if (have_peak_q) begin
          raw_upd     = 1'b1;
          prev_p_d    = raw_p;
          have_prev_d = 1'b1;
          if (have_prev_q) begin
            locked_d = (p_diff <= CNT_W'(TOL));
          end
        end
      end else if (sil_hit) begin
        sil_d       = '0;
        have_peak_d = 1'b0;
        have_prev_d = 1'b0;
        locked_d    = 1'b0;
        to_d        = 1'b1;
      end
    end
  end

`ifdef PITCH_DETECTOR_AVG_EN
  localparam int unsigned SumW = CNT_W + 2;

  logic [3:0][CNT_W-1:0] hist_q, hist_d;
  logic [2:0]            hcnt_q, hcnt_d;
  logic [SumW-1:0]       hist_sum;

  // Output only once the history holds 4 raw periods since the last INIT.
  always_comb begin
    hist_d   = hist_q;
    hcnt_d   = hcnt_q;
    period_d = period_q;
    pv_d     = 1'b0;
    hist_sum = '0;
    if (timeout_evt) begin
      hist_d = '0;
      hcnt_d = '0;
    end else if (raw_upd) begin
      hist_d   = {hist_q[2:0], raw_p};
      hist_sum = SumW'(hist_d[0]) + SumW'(hist_d[1]) + SumW'(hist_d[2]) + SumW'(hist_d[3]);
      if (hcnt_q != 3'd4) begin
        hcnt_d = hcnt_q + 3'd1;
      end
      if (hcnt_q >= 3'd3) begin
        period_d = hist_sum[SumW-1:2];
        pv_d     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= '0;
      hcnt_q <= '0;
    end else begin
      hist_q <= hist_d;
      hcnt_q <= hcnt_d;
    end
  end
`else
  always_comb begin
    period_d = raw_upd ? raw_p : period_q;
    pv_d     = raw_upd;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StInit;
      idx_q       <= '0;
      max_idx_q   <= '0;
      last_idx_q  <= '0;
      prev_p_q    <= '0;
      period_q    <= '0;
      sil_q       <= '0;
      max_q       <= '0;
      min_q       <= '0;
      have_peak_q <= 1'b0;
      have_prev_q <= 1'b0;
      locked_q    <= 1'b0;
      pv_q        <= 1'b0;
      to_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      max_idx_q   <= max_idx_d;
      last_idx_q  <= last_idx_d;
      prev_p_q    <= prev_p_d;
      period_q    <= period_d;
      sil_q       <= sil_d;
      max_q       <= max_d;
      min_q       <= min_d;
      have_peak_q <= have_peak_d;
      have_prev_q <= have_prev_d;
      locked_q    <= locked_d;
      pv_q        <= pv_d;
      to_q        <= to_d;
    end
  end

  assign period       = period_q;
  assign period_valid = pv_q;
  assign locked       = locked_q;
  assign timeout      = to_q;

endmodule
